// File: rtl/rv_commit_arbiter_pkg.sv
// Shared constants and types for the commit arbiter: per-thread field widths,
// commit source indices and the writeback beat layout.
package rv_commit_arbiter_pkg;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NW_BITS     = 2;
    localparam int unsigned UUID_BITS   = 44;
    localparam int unsigned NR_BITS     = 5;
    localparam int unsigned XLEN        = 32;

    typedef enum logic [2:0] {
        SRC_ALU   = 3'd0,
        SRC_LSU   = 3'd1,
        SRC_CSR   = 3'd2,
        SRC_FPU   = 3'd3,
        SRC_GPU   = 3'd4,
        SRC_SPARE = 3'd5
    } commit_src_e;

    typedef struct packed {
        logic [UUID_BITS-1:0]        uuid;
        logic [NW_BITS-1:0]          wid;
        logic [NUM_THREADS-1:0]      tmask;
        logic [XLEN-1:0]             pc;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic [NR_BITS-1:0]          rd;
        logic                        eop;
    } wb_beat_t;

    // Width able to hold every thread of every source committing at once.
    function automatic int unsigned commit_size_bits(input int unsigned n_src);
        return $clog2(n_src * NUM_THREADS + 1);
    endfunction

endpackage

// File: rtl/rv_commit_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with
// wrap-around; the pointer moves past the winner only when en_i allows a grant.
module rv_commit_arbiter_rr #(
    parameter int unsigned NUM_REQS = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_REQS-1:0] req_i,
    input  logic                en_i,
    output logic [NUM_REQS-1:0] grant_o
);

    localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] hi_sel_s;
    logic [IDX_W-1:0] lo_sel_s;
    logic [IDX_W-1:0] sel_s;
    logic             hi_found_s;
    logic             lo_found_s;

    // Winner search: first request at or above the pointer, else first overall.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_sel_s   = '0;
        lo_sel_s   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!hi_found_s && req_i[i] && (IDX_W'(i) >= ptr_q)) begin
                hi_found_s = 1'b1;
                hi_sel_s   = IDX_W'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
            if (!lo_found_s && req_i[i]) begin
                lo_found_s = 1'b1;
                lo_sel_s   = IDX_W'(i);
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        sel_s = hi_found_s ? hi_sel_s : lo_sel_s;
        for (int i = 0; i < NUM_REQS; i++) begin
            grant_o[i] = lo_found_s && (sel_s == IDX_W'(i));
        end
    end

    // Pointer next state: one past the winner, wrapping at the last index.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && lo_found_s) begin
            ptr_d = (sel_s == IDX_W'(NUM_REQS - 1)) ? '0 : sel_s + IDX_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rv_commit_arbiter.sv
// Commit arbiter: merges per-unit commits into one registered writeback beat
// and reports the number of committed threads to the CSR block each cycle.
module rv_commit_arbiter
    import rv_commit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned CORE_ID = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_SRC-1:0]                src_valid_i,
    output logic [NUM_SRC-1:0]                src_ready_o,
    input  logic [NUM_SRC*UUID_BITS-1:0]      src_uuid_i,
    input  logic [NUM_SRC*NW_BITS-1:0]        src_wid_i,
    input  logic [NUM_SRC*NUM_THREADS-1:0]    src_tmask_i,
    input  logic [NUM_SRC*XLEN-1:0]           src_pc_i,
    input  logic [NUM_SRC*NUM_THREADS*XLEN-1:0] src_data_i,
    input  logic [NUM_SRC*NR_BITS-1:0]        src_rd_i,
    input  logic [NUM_SRC-1:0]                src_wb_i,
    input  logic [NUM_SRC-1:0]                src_eop_i,
    output logic                              wb_valid_o,
    output logic [UUID_BITS-1:0]              wb_uuid_o,
    output logic [NW_BITS-1:0]                wb_wid_o,
    output logic [NUM_THREADS-1:0]            wb_tmask_o,
    output logic [XLEN-1:0]                   wb_pc_o,
    output logic [NUM_THREADS*XLEN-1:0]       wb_data_o,
    output logic [NR_BITS-1:0]                wb_rd_o,
    output logic                              wb_eop_o,
    input  logic                              wb_ready_i,
    output logic                              cmt_to_csr_if_valid_o,
    output logic [commit_size_bits(NUM_SRC)-1:0] cmt_to_csr_if_commit_size_o
);

    localparam int unsigned CMT_W = commit_size_bits(NUM_SRC);
    localparam int unsigned DW    = NUM_THREADS * XLEN;

    logic [NUM_SRC-1:0] wb_req_s;
    logic [NUM_SRC-1:0] arb_grant_s;
    logic [NUM_SRC-1:0] grant_s;
    logic [NUM_SRC-1:0] ready_s;
    logic [NUM_SRC-1:0] fire_s;
    logic               stage_free_s;
    wb_beat_t           beat_s;
    wb_beat_t           stage_d;
    wb_beat_t           stage_q;
    logic               wb_valid_d;
    logic               wb_valid_q;
    logic               cmt_valid_d;
    logic               cmt_valid_q;
    logic [CMT_W-1:0]   cmt_size_d;
    logic [CMT_W-1:0]   cmt_size_q;

    rv_commit_arbiter_rr #(
        .NUM_REQS (NUM_SRC)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (wb_req_s),
        .en_i    (stage_free_s),
        .grant_o (arb_grant_s)
    );

    // Handshake: no-writeback sources pass freely, writeback sources need a grant;
    // nothing is accepted while reset is held.
    always_comb begin
        wb_req_s     = src_valid_i & src_wb_i;
        stage_free_s = ~wb_valid_q | wb_ready_i;
        grant_s      = arb_grant_s & {NUM_SRC{stage_free_s}};
        ready_s      = rst_ni ? ((src_valid_i & ~src_wb_i) | grant_s) : '0;
        fire_s       = src_valid_i & ready_s;
    end

    // One-hot AND-OR mux of the granted source into a writeback beat.
    always_comb begin
        beat_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            beat_s.uuid  = beat_s.uuid  | (src_uuid_i[i*UUID_BITS +: UUID_BITS]       & {UUID_BITS{grant_s[i]}});
            beat_s.wid   = beat_s.wid   | (src_wid_i[i*NW_BITS +: NW_BITS]            & {NW_BITS{grant_s[i]}});
            beat_s.tmask = beat_s.tmask | (src_tmask_i[i*NUM_THREADS +: NUM_THREADS]  & {NUM_THREADS{grant_s[i]}});
            beat_s.pc    = beat_s.pc    | (src_pc_i[i*XLEN +: XLEN]                   & {XLEN{grant_s[i]}});
            beat_s.data  = beat_s.data  | (src_data_i[i*DW +: DW]                     & {DW{grant_s[i]}});
            beat_s.rd    = beat_s.rd    | (src_rd_i[i*NR_BITS +: NR_BITS]             & {NR_BITS{grant_s[i]}});
            beat_s.eop   = beat_s.eop   | (src_eop_i[i] & grant_s[i]);
        end
    end

    // Output stage: load on grant (also when draining), otherwise drop valid on drain.
    always_comb begin
        stage_d    = stage_q;
        wb_valid_d = wb_valid_q;
        if (|grant_s) begin
            stage_d    = beat_s;
            wb_valid_d = 1'b1;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end
    end

    // Thread count of every firing source, writeback or not.
    always_comb begin
        cmt_valid_d = |fire_s;
        cmt_size_d  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                cmt_size_d = cmt_size_d + CMT_W'(fire_s[i] & src_tmask_i[i*NUM_THREADS + t]);
            end
        end
    end

    // Writeback and commit-count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q     <= '0;
            wb_valid_q  <= 1'b0;
            cmt_valid_q <= 1'b0;
            cmt_size_q  <= '0;
        end else begin
            stage_q     <= stage_d;
            wb_valid_q  <= wb_valid_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_size_q  <= cmt_size_d;
        end
    end

    assign src_ready_o                 = ready_s;
    assign wb_valid_o                  = wb_valid_q;
    assign wb_uuid_o                   = stage_q.uuid;
    assign wb_wid_o                    = stage_q.wid;
    assign wb_tmask_o                  = stage_q.tmask;
    assign wb_pc_o                     = stage_q.pc;
    assign wb_data_o                   = stage_q.data;
    assign wb_rd_o                     = stage_q.rd;
    assign wb_eop_o                    = stage_q.eop;
    assign cmt_to_csr_if_valid_o       = cmt_valid_q;
    assign cmt_to_csr_if_commit_size_o = cmt_size_q;

endmodule

// File: tb/tb_rv_commit_arbiter.sv
// Directed and random checks of rv_commit_arbiter against a cycle-level
// reference model of the commit/writeback rules.
module tb_rv_commit_arbiter;
    import rv_commit_arbiter_pkg::*;

    localparam int N  = 6;
    localparam int NT = NUM_THREADS;
    localparam int CW = commit_size_bits(N);
    localparam int DW = NT * XLEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wb_ready = 1'b1;

    logic [N-1:0]           s_valid, s_wb, s_eop;
    logic [NT-1:0]          s_tmask [N];
    logic [UUID_BITS-1:0]   s_uuid  [N];
    logic [NW_BITS-1:0]     s_wid   [N];
    logic [XLEN-1:0]        s_pc    [N];
    logic [DW-1:0]          s_data  [N];
    logic [NR_BITS-1:0]     s_rd    [N];

    logic [N*UUID_BITS-1:0] f_uuid;
    logic [N*NW_BITS-1:0]   f_wid;
    logic [N*NT-1:0]        f_tmask;
    logic [N*XLEN-1:0]      f_pc;
    logic [N*DW-1:0]        f_data;
    logic [N*NR_BITS-1:0]   f_rd;

    logic [N-1:0]           src_ready;
    logic                   wb_valid, wb_eop, cmt_valid;
    logic [UUID_BITS-1:0]   wb_uuid;
    logic [NW_BITS-1:0]     wb_wid;
    logic [NT-1:0]          wb_tmask;
    logic [XLEN-1:0]        wb_pc;
    logic [DW-1:0]          wb_data;
    logic [NR_BITS-1:0]     wb_rd;
    logic [CW-1:0]          cmt_size;

    int tests = 0;
    int fails = 0;

    int       m_ptr = 0,  n_ptr = 0;
    logic     m_valid = 1'b0, n_valid = 1'b0;
    wb_beat_t m_beat = '0, n_beat = '0;
    logic     m_cv = 1'b0, n_cv = 1'b0;
    int       m_cs = 0,   n_cs = 0;

    always #5 clk = ~clk;

    always_comb begin
        f_uuid = '0; f_wid = '0; f_tmask = '0; f_pc = '0; f_data = '0; f_rd = '0;
        for (int i = 0; i < N; i++) begin
            f_uuid[i*UUID_BITS +: UUID_BITS] = s_uuid[i];
            f_wid[i*NW_BITS +: NW_BITS]      = s_wid[i];
            f_tmask[i*NT +: NT]              = s_tmask[i];
            f_pc[i*XLEN +: XLEN]             = s_pc[i];
            f_data[i*DW +: DW]               = s_data[i];
            f_rd[i*NR_BITS +: NR_BITS]       = s_rd[i];
        end
    end

    rv_commit_arbiter #(.NUM_SRC(N), .CORE_ID(0)) dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_n),
        .src_valid_i                 (s_valid),
        .src_ready_o                 (src_ready),
        .src_uuid_i                  (f_uuid),
        .src_wid_i                   (f_wid),
        .src_tmask_i                 (f_tmask),
        .src_pc_i                    (f_pc),
        .src_data_i                  (f_data),
        .src_rd_i                    (f_rd),
        .src_wb_i                    (s_wb),
        .src_eop_i                   (s_eop),
        .wb_valid_o                  (wb_valid),
        .wb_uuid_o                   (wb_uuid),
        .wb_wid_o                    (wb_wid),
        .wb_tmask_o                  (wb_tmask),
        .wb_pc_o                     (wb_pc),
        .wb_data_o                   (wb_data),
        .wb_rd_o                     (wb_rd),
        .wb_eop_o                    (wb_eop),
        .wb_ready_i                  (wb_ready),
        .cmt_to_csr_if_valid_o       (cmt_valid),
        .cmt_to_csr_if_commit_size_o (cmt_size)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic wb, input logic [NT-1:0] tm);
        s_valid[i] = v;
        s_wb[i]    = wb;
        s_tmask[i] = tm;
        s_uuid[i]  = {12'(i), $urandom};
        s_wid[i]   = NW_BITS'($urandom);
        s_pc[i]    = $urandom;
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        s_rd[i]    = NR_BITS'($urandom);
        s_eop[i]   = 1'($urandom);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, 1'b0, '0);
    endtask

    // Reference: pick winner from pointer, accept free sources, count threads.
    task automatic model_eval();
        int g;
        int sz;
        logic [N-1:0] er;
        logic [N-1:0] fire;
        g = -1;
        if (!m_valid || wb_ready) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && s_valid[idx] && s_wb[idx]) g = idx;
            end
        end
        for (int i = 0; i < N; i++) er[i] = (s_valid[i] && !s_wb[i]) || (i == g);
        chk("src_ready", 128'(src_ready), 128'(er));
        fire = s_valid & er;
        sz = 0;
        for (int i = 0; i < N; i++) if (fire[i]) sz += $countones(s_tmask[i]);
        n_cv = |fire;
        n_cs = sz;
        n_beat = m_beat;
        n_ptr  = m_ptr;
        if (g >= 0) begin
            n_valid = 1'b1;
            n_ptr   = (g + 1) % N;
            n_beat  = '{uuid: s_uuid[g], wid: s_wid[g], tmask: s_tmask[g], pc: s_pc[g],
                        data: s_data[g], rd: s_rd[g], eop: s_eop[g]};
        end else begin
            n_valid = wb_ready ? 1'b0 : m_valid;
        end
    endtask

    task automatic check_out();
        chk("wb_valid",  128'(wb_valid),  128'(m_valid));
        chk("wb_uuid",   128'(wb_uuid),   128'(m_beat.uuid));
        chk("wb_wid",    128'(wb_wid),    128'(m_beat.wid));
        chk("wb_tmask",  128'(wb_tmask),  128'(m_beat.tmask));
        chk("wb_pc",     128'(wb_pc),     128'(m_beat.pc));
        chk("wb_data",   wb_data,         m_beat.data);
        chk("wb_rd",     128'(wb_rd),     128'(m_beat.rd));
        chk("wb_eop",    128'(wb_eop),    128'(m_beat.eop));
        chk("cmt_valid", 128'(cmt_valid), 128'(m_cv));
        chk("cmt_size",  128'(cmt_size),  128'(m_cs));
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        m_valid = n_valid; m_beat = n_beat; m_ptr = n_ptr; m_cv = n_cv; m_cs = n_cs;
        check_out();
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_beat = '0; m_ptr = 0; m_cv = 1'b0; m_cs = 0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        chk("rst_ready", 128'(src_ready), 128'(0));
        @(posedge clk);
        #1;
        check_out();
        #1;
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] held_data;

    initial begin
        clear_all();
        #3;
        check_out();
        chk("rst_ready0", 128'(src_ready), 128'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ALU and CSR together: ALU first, CSR next.
        set_src(SRC_ALU, 1'b1, 1'b1, 4'b1111);
        set_src(SRC_CSR, 1'b1, 1'b1, 4'b0011);
        step();
        chk("r034_src1",  128'(wb_uuid[UUID_BITS-1 -: 12]), 128'(0));
        chk("r034_size1", 128'(cmt_size), 128'(4));
        s_valid[SRC_ALU] = 1'b0;
        step();
        chk("r034_src2",  128'(wb_uuid[UUID_BITS-1 -: 12]), 128'(2));
        chk("r034_size2", 128'(cmt_size), 128'(2));
        clear_all();
        step();

        // Backpressure: stage holds, pending writeback source is refused.
        set_src(SRC_ALU, 1'b1, 1'b1, 4'b0101);
        set_src(SRC_LSU, 1'b1, 1'b1, 4'b1000);
        held_data = s_data[SRC_ALU];
        step();
        s_valid[SRC_ALU] = 1'b0;
        wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("r035_hold", wb_data, held_data);
            chk("r035_lsu_rdy", 128'(src_ready[SRC_LSU]), 128'(0));
        end
        wb_ready = 1'b1;
        step();
        chk("r035_next", 128'(wb_uuid[UUID_BITS-1 -: 12]), 128'(1));
        clear_all();
        step();

        // Non-writeback LSU and writeback FPU fire together.
        set_src(SRC_LSU, 1'b1, 1'b0, 4'b1010);
        set_src(SRC_FPU, 1'b1, 1'b1, 4'b0001);
        step();
        chk("r036_size", 128'(cmt_size), 128'(3));
        chk("r036_src",  128'(wb_uuid[UUID_BITS-1 -: 12]), 128'(3));
        chk("r036_tm",   128'(wb_tmask), 128'(4'b0001));
        clear_all();
        step();

        // Reset in the middle of a held beat.
        set_src(SRC_ALU, 1'b1, 1'b1, 4'b0110);
        set_src(SRC_GPU, 1'b1, 1'b0, 4'b1111);
        wb_ready = 1'b0;
        step();
        chk("r038_pre", 128'(wb_valid), 128'(1));
        do_reset();
        wb_ready = 1'b1;

        // All sources writeback: strict rotation from index 0.
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 4'b0011);
        for (int c = 0; c < 7; c++) begin
            step();
            chk("r037_rot", 128'(wb_uuid[UUID_BITS-1 -: 12]), 128'(c % N));
            chk("r037_beat", 128'(wb_valid), 128'(1));
        end

        // All sources non-writeback with full masks: maximum count.
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b0, 4'b1111);
        step();
        chk("r039_size",  128'(cmt_size), 128'(24));
        chk("r039_valid", 128'(cmt_valid), 128'(1));
        clear_all();
        step();

        // Random traffic with a mid-run reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_src(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NT'($urandom));
            wb_ready = ($urandom_range(0, 3) != 0);
            step();
            if (c == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
